alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit signed add/subtract unit among NREQ requesters.
- Each requester is typically a PID term calculation (P, I, D) in the balance-control math path.
- The block grants one requester, latches its operands and runs the add/sub.
- It then presents a registered result with a signed-overflow flag under a valid/ready handshake.

Parameters:
- NREQ, 3, number of requesters (2..8).
- PTR_W, 2, width of the round-robin pointer and of res_id; must satisfy 2^PTR_W >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_vld  input  NREQ  per-requester operation request.
- req_a  input  8*NREQ  flattened operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  flattened operand B; requester i uses bits [8i+7:8i].
- req_sub  input  NREQ  per-requester op select: 1 = A-B, 0 = A+B.
- req_gnt  output  NREQ  one-hot grant; operands are captured on the same edge.
- res_vld  output  1  result valid.
- res_rdy  input  1  result consumer ready.
- res_id  output  PTR_W  index of the requester that owns the result.
- res_sum  output  8  result (two's complement).
- res_ov  output  1  signed overflow of the operation.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - Operand and result registers cleared.
  - res_vld=0, res_sum=0x00, res_ov=0, res_id=0, req_gnt=0, busy=0.
- States are IDLE, EXEC and RESP.
- IDLE:
  - If any req_vld bit is set, select the first set bit searching upward from rr_ptr, wrapping at NREQ-1 back to 0.
  - req_gnt is combinational in IDLE: the winner's bit is high during the selection cycle only.
  - On that clock edge:
    - Capture the winner's A, B and sub into the operand registers.
    - Capture the winner index into id_q.
    - rr_ptr <= (winner+1) mod NREQ.
    - state <= EXEC.
  - With no requests, remain in IDLE and leave rr_ptr unchanged.
- EXEC:
  - Compute SUM = A + (sub ? ~B : B) + sub, mod 256.
  - OV = (both adder inputs have bit7=0 and SUM[7]=1) or (both adder inputs have bit7=1 and SUM[7]=0). The adder inputs are A and the conditionally inverted B.
  - Register SUM into res_sum, OV into res_ov and id_q into res_id; state <= RESP.
  - req_gnt=0.
- RESP:
  - res_vld=1; res_sum, res_ov and res_id are held stable until res_vld & res_rdy.
  - On handshake, state <= IDLE and res_vld falls on the next cycle.
  - No grant is issued while in RESP.
- Latency: grant edge to res_vld high is 2 clocks. Minimum issue interval is 3 clocks (IDLE, EXEC, RESP with res_rdy=1).
- Requester protocol: a requester holds req_vld and its operands stable until it sees its req_gnt bit. It may deassert req_vld, or present a new operation, in the cycle after the grant.
- Changes on req_vld, req_a, req_b or req_sub outside IDLE have no effect on the operation in flight.
- Fairness: every continuously asserted requester is granted within NREQ grants.
- Reset asserted mid-operation aborts immediately; the in-flight result is discarded and res_vld=0.
- Requester indices >= NREQ never appear on res_id.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: when OV=1 in EXEC, res_sum saturates instead of wrapping.
  - Saturate to 0x7F when the adder inputs were both non-negative.
  - Saturate to 0x80 when they were both negative.
  - res_ov still reports 1.
- Undefined: res_sum is the wrapped 8-bit result. No saturation logic is synthesized.

Test Plan:
1. Reset, then req_vld=3'b001 with A=0x50, B=0x40, sub=0 -> req_gnt=001 for one cycle; 2 clocks later res_vld=1, res_sum=0x90 (0x7F with ALU_SAT_EN), res_ov=1, res_id=0.
2. Requester 1 with A=0x05, B=0x07, sub=1 -> res_sum=0xFE, res_ov=0, res_id=1. Requester 2 with A=0x80, B=0x01, sub=1 -> res_sum=0x7F (0x80 with ALU_SAT_EN), res_ov=1.
3. All three req_vld held high, res_rdy=1 -> grant order 0,1,2,0,1 with exactly one grant every 3 clocks; res_id follows the same sequence.
4. res_rdy low for 5 cycles while in RESP, with other requests pending -> res_vld, res_sum and res_id stay stable and req_gnt=0. Release res_rdy -> the next grant occurs 1 cycle after the handshake.
5. Assert rst_n=0 during EXEC -> res_vld=0, busy=0 and rr_ptr=0 immediately. After release, pending requests are granted starting from requester 0.
6. NREQ=2 build: both requesting -> grants alternate 0,1,0,1; res_id never exceeds 1.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request/result bus between NREQ add/sub requesters, the result consumer and alu_share_arb.
// master: requesters and result consumer; slave: the arbiter.
interface alu_share_arb_if #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
);
    logic [NREQ-1:0]   req_vld;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ-1:0]   req_gnt;
    logic              res_vld;
    logic              res_rdy;
    logic [PTR_W-1:0]  res_id;
    logic [7:0]        res_sum;
    logic              res_ov;

    modport master (
        output req_vld, req_a, req_b, req_sub, res_rdy,
        input  req_gnt, res_vld, res_id, res_sum, res_ov
    );

    modport slave (
        input  req_vld, req_a, req_b, req_sub, res_rdy,
        output req_gnt, res_vld, res_id, res_sum, res_ov
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one 8-bit signed add/sub unit among NREQ requesters.
// Define ALU_SAT_EN to saturate res_sum on signed overflow instead of wrapping.
module alu_share_arb #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus,
    output logic           busy
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] id_q, id_d;
    logic [PTR_W-1:0] res_id_q, res_id_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic [7:0]       res_sum_q, res_sum_d;
    logic             sub_q, sub_d;
    logic             res_ov_q, res_ov_d;

    logic             found_hi, found_lo, found;
    logic [PTR_W-1:0] win_hi, win_lo, win_idx;
    logic [7:0]       b_eff, sum, sum_out;
    logic             ov;

    // Lowest requester at/above rr_ptr wins; otherwise lowest below it (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int j = int'(NREQ) - 1; j >= 0; j--) begin
            if (bus.req_vld[j]) begin
                if (PTR_W'(j) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    win_hi   = PTR_W'(j);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = PTR_W'(j);
                end
            end
        end
        found   = found_hi | found_lo;
        win_idx = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        bus.req_gnt = '0;
        if (state_q == StIdle && found) begin
            for (int j = 0; j < int'(NREQ); j++) begin
                bus.req_gnt[j] = (win_idx == PTR_W'(j));
            end
        end
    end

    always_comb begin
        b_eff = sub_q ? ~b_q : b_q;
        sum   = a_q + b_eff + {7'd0, sub_q};
        ov    = (a_q[7] == b_eff[7]) && (sum[7] != a_q[7]);
`ifdef ALU_SAT_EN
        sum_out = ov ? (a_q[7] ? 8'h80 : 8'h7F) : sum;
`else
        sum_out = sum;
`endif
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        res_sum_d = res_sum_q;
        res_ov_d  = res_ov_q;
        res_id_d  = res_id_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    for (int j = 0; j < int'(NREQ); j++) begin
                        if (win_idx == PTR_W'(j)) begin
                            a_d   = bus.req_a[8*j +: 8];
                            b_d   = bus.req_b[8*j +: 8];
                            sub_d = bus.req_sub[j];
                        end
                    end
                    id_d     = win_idx;
                    rr_ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    state_d  = StExec;
                end
            end
            StExec: begin
                res_sum_d = sum_out;
                res_ov_d  = ov;
                res_id_d  = id_q;
                state_d   = StResp;
            end
            StResp: begin
                if (bus.res_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            res_sum_q <= '0;
            res_ov_q  <= 1'b0;
            res_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            res_sum_q <= res_sum_d;
            res_ov_q  <= res_ov_d;
            res_id_q  <= res_id_d;
        end
    end

    assign bus.res_vld = (state_q == StResp);
    assign bus.res_sum = res_sum_q;
    assign bus.res_ov  = res_ov_q;
    assign bus.res_id  = res_id_q;
    assign busy        = (state_q != StIdle);
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vector table, multi-cycle corner
// sequences, a 2-requester instance and a randomized run against a transaction model.
module tb_alu_share_arb;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic busy3, busy2;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arb_if #(.NREQ(3), .PTR_W(2)) bus3 ();
    alu_share_arb_if #(.NREQ(2), .PTR_W(1)) bus2 ();

    alu_share_arb #(.NREQ(3), .PTR_W(2)) dut3 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus3),
        .busy (busy3)
    );

    alu_share_arb #(.NREQ(2), .PTR_W(1)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2),
        .busy (busy2)
    );

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum_wrap;
        logic [7:0] sum_sat;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed reference arithmetic: {ov, sum}
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub);
        int         sa, sb, r;
        logic       o;
        logic [7:0] s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        o  = (r > 127) || (r < -128);
        s  = 8'(r);
        if (SAT && o) s = (r > 0) ? 8'h7F : 8'h80;
        return {o, s};
    endfunction

    function automatic int rr_pick(input int ptr, input int n, input logic [7:0] vld);
        for (int k = 0; k < n; k++) begin
            if (vld[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain3(input string tag);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!busy3 && !bus3.res_vld && bus3.req_gnt == '0) break;
        end
        check($sformatf("%s drain idle", tag), {31'd0, busy3}, 32'd0);
    endtask

    task automatic run_single(input string tag, input int idx, input logic [7:0] a,
                              input logic [7:0] b, input logic sub,
                              input logic [7:0] es, input logic eo);
        int waited;
        @(posedge clk);
        #1;
        bus3.req_vld            = '0;
        bus3.req_a[8*idx +: 8]  = a;
        bus3.req_b[8*idx +: 8]  = b;
        bus3.req_sub[idx]       = sub;
        bus3.req_vld[idx]       = 1'b1;
        waited = 0;
        @(negedge clk);
        while (bus3.req_gnt == '0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s gnt", tag), bus3.req_gnt, 32'(1 << idx));
        @(posedge clk);
        #1;
        bus3.req_vld = '0;
        @(negedge clk);
        check($sformatf("%s exec vld", tag), bus3.res_vld, 0);
        check($sformatf("%s exec busy", tag), busy3, 1);
        check($sformatf("%s exec gnt", tag), bus3.req_gnt, 0);
        @(negedge clk);
        check($sformatf("%s res_vld", tag), bus3.res_vld, 1);
        check($sformatf("%s res_sum", tag), bus3.res_sum, es);
        check($sformatf("%s res_ov", tag), bus3.res_ov, eo);
        check($sformatf("%s res_id", tag), bus3.res_id, idx);
        @(negedge clk);
        check($sformatf("%s vld drop", tag), bus3.res_vld, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[10];
        int         gcount, rcount, last, w, vld_from;
        logic [2:0] exp_gnt;
        logic       inflight, exp_vld;
        int         ptr;
        logic [8:0] txn;
        int         txn_id;

        vecs[0] = '{0, 8'h50, 8'h40, 1'b0, 8'h90, 8'h7F, 1'b1};
        vecs[1] = '{1, 8'h05, 8'h07, 1'b1, 8'hFE, 8'hFE, 1'b0};
        vecs[2] = '{2, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1};
        vecs[3] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b1};
        vecs[4] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1};
        vecs[5] = '{2, 8'h00, 8'h80, 1'b1, 8'h80, 8'h7F, 1'b1};
        vecs[6] = '{0, 8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{2, 8'h10, 8'h20, 1'b1, 8'hF0, 8'hF0, 1'b0};
        vecs[9] = '{0, 8'hC0, 8'hC0, 1'b0, 8'h80, 8'h80, 1'b0};

        rst_n = 1'b1;
        bus3.req_vld = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_sub = '0;
        bus3.res_rdy = 1'b1;
        bus2.req_vld = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.req_sub = '0;
        bus2.res_rdy = 1'b1;

        // Reset state
        do_reset();
        #1;
        check("rst res_vld", bus3.res_vld, 0);
        check("rst res_sum", bus3.res_sum, 0);
        check("rst res_ov", bus3.res_ov, 0);
        check("rst res_id", bus3.res_id, 0);
        check("rst gnt", bus3.req_gnt, 0);
        check("rst busy", busy3, 0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sub,
                       SAT ? vecs[i].sum_sat : vecs[i].sum_wrap, vecs[i].ov);
        end

        // All three requesting: order 0,1,2,0,1 at one grant per 3 clocks
        do_reset();
        @(posedge clk);
        #1;
        bus3.req_a = {8'h03, 8'h02, 8'h01};
        bus3.req_b = {8'h01, 8'h01, 8'h01};
        bus3.req_sub = 3'b000;
        bus3.req_vld = 3'b111;
        gcount = 0; rcount = 0; last = 0;
        for (int cyc = 0; cyc < 40 && rcount < 5; cyc++) begin
            @(negedge clk);
            if (bus3.req_gnt != '0 && gcount < 5) begin
                check($sformatf("rr gnt%0d", gcount), bus3.req_gnt, 32'(1 << (gcount % 3)));
                if (gcount > 0) check($sformatf("rr gap%0d", gcount), cyc - last, 3);
                last = cyc;
                gcount++;
            end
            if (bus3.res_vld) begin
                check($sformatf("rr id%0d", rcount), bus3.res_id, rcount % 3);
                check($sformatf("rr sum%0d", rcount), bus3.res_sum, (rcount % 3) + 2);
                rcount++;
            end
        end
        check("rr grant count", gcount, 5);
        check("rr result count", rcount, 5);
        @(posedge clk);
        #1;
        bus3.req_vld = '0;
        drain3("rr");

        // Backpressure in RESP with another request pending
        do_reset();
        @(posedge clk);
        #1;
        bus3.res_rdy = 1'b0;
        bus3.req_a = {8'h00, 8'h30, 8'h11};
        bus3.req_b = {8'h00, 8'h05, 8'h22};
        bus3.req_sub = 3'b010;
        bus3.req_vld = 3'b011;
        @(negedge clk);
        check("bp gnt0", bus3.req_gnt, 3'b001);
        @(posedge clk);
        #1;
        bus3.req_vld = 3'b010;
        @(negedge clk);
        check("bp exec gnt", bus3.req_gnt, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d vld", k), bus3.res_vld, 1);
            check($sformatf("bp%0d sum", k), bus3.res_sum, 8'h33);
            check($sformatf("bp%0d id", k), bus3.res_id, 0);
            check($sformatf("bp%0d gnt", k), bus3.req_gnt, 0);
        end
        @(posedge clk);
        #1;
        bus3.res_rdy = 1'b1;
        @(negedge clk);
        check("bp hs vld", bus3.res_vld, 1);
        @(negedge clk);
        check("bp post vld", bus3.res_vld, 0);
        check("bp next gnt", bus3.req_gnt, 3'b010);
        @(posedge clk);
        #1;
        bus3.req_vld = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp next sum", bus3.res_sum, 8'h2B);
        drain3("bp");

        // Reset during EXEC
        do_reset();
        @(posedge clk);
        #1;
        bus3.req_vld = 3'b010;
        @(negedge clk);
        check("rx gnt1", bus3.req_gnt, 3'b010);
        @(posedge clk);
        #1;
        bus3.req_vld = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rx vld", bus3.res_vld, 0);
        check("rx busy", busy3, 0);
        @(negedge clk);
        @(negedge clk);
        check("rx vld held", bus3.res_vld, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus3.req_vld = 3'b111;
        @(negedge clk);
        check("rx restart gnt", bus3.req_gnt, 3'b001);
        @(posedge clk);
        #1;
        bus3.req_vld = '0;
        drain3("rx");

        // Two-requester instance alternates 0,1
        do_reset();
        @(posedge clk);
        #1;
        bus2.req_a = {8'h03, 8'h01};
        bus2.req_b = {8'h01, 8'h02};
        bus2.req_sub = 2'b10;
        bus2.req_vld = 2'b11;
        gcount = 0; rcount = 0;
        for (int cyc = 0; cyc < 40 && rcount < 6; cyc++) begin
            @(negedge clk);
            if (bus2.req_gnt != '0 && gcount < 6) begin
                check($sformatf("n2 gnt%0d", gcount), bus2.req_gnt, 32'(1 << (gcount % 2)));
                gcount++;
            end
            if (bus2.res_vld) begin
                check($sformatf("n2 id%0d", rcount), bus2.res_id, rcount % 2);
                check($sformatf("n2 sum%0d", rcount), bus2.res_sum, (rcount % 2) ? 2 : 3);
                rcount++;
            end
        end
        check("n2 result count", rcount, 6);
        @(posedge clk);
        #1;
        bus2.req_vld = '0;

        // Randomized run against transaction-level model
        do_reset();
        ptr = 0; inflight = 1'b0; vld_from = 0; exp_gnt = '0; txn = '0; txn_id = 0;
        bus3.req_vld = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (exp_gnt[i] || !bus3.req_vld[i]) begin
                    if ($urandom_range(0, exp_gnt[i] ? 1 : 2) == 0) begin
                        bus3.req_a[8*i +: 8] = 8'($urandom);
                        bus3.req_b[8*i +: 8] = 8'($urandom);
                        bus3.req_sub[i]      = 1'($urandom);
                        bus3.req_vld[i]      = 1'b1;
                    end else begin
                        bus3.req_a[8*i +: 8] = 8'($urandom);
                        bus3.req_vld[i]      = 1'b0;
                    end
                end
            end
            bus3.res_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w = -1;
            exp_gnt = '0;
            if (!inflight) begin
                w = rr_pick(ptr, 3, {5'd0, bus3.req_vld});
                if (w >= 0) exp_gnt = 3'(1 << w);
            end
            exp_vld = inflight && (cyc >= vld_from);
            check("rnd gnt", bus3.req_gnt, exp_gnt);
            check("rnd busy", busy3, inflight);
            check("rnd res_vld", bus3.res_vld, exp_vld);
            if (exp_vld) begin
                check("rnd res_sum", bus3.res_sum, txn[7:0]);
                check("rnd res_ov", bus3.res_ov, txn[8]);
                check("rnd res_id", bus3.res_id, txn_id);
            end
            if (w >= 0) begin
                txn      = ref_alu(bus3.req_a[8*w +: 8], bus3.req_b[8*w +: 8], bus3.req_sub[w]);
                txn_id   = w;
                inflight = 1'b1;
                vld_from = cyc + 2;
                ptr      = (w + 1) % 3;
            end else if (exp_vld && bus3.res_rdy) begin
                inflight = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
